// File: rtl/q_stream_rx.sv
// rtl/q_stream_rx.sv - LSB-first serial-to-word receiver with output FIFO and sticky error flags.
// Optional even-parity frame bit enabled by defining Q_STREAM_RX_PARITY_EN.
module q_stream_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic                         bit_in,
  input  logic                         bit_en,
  input  logic                         flush,
  input  logic                         clr_ovf,
  output logic [WIDTH-1:0]             word_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         overflow,
  output logic                         parity_err
);

`ifdef Q_STREAM_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int BW = $clog2(FRAME);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] frame_word;
  logic             complete;
  logic             word_good;
  logic             pop;
  logic             push;
  logic             ovf_set;

  // Shifting past WIDTH (the parity position) contributes nothing to the data word.
  assign word_next  = shreg | (WIDTH'(bit_in) << bcnt);
  assign complete   = bit_en && !flush && (bcnt == BW'(FRAME - 1));
  assign word_valid = (fill_count != '0);
  assign word_data  = mem[rptr];
  assign pop        = word_valid && word_ready;

`ifdef Q_STREAM_RX_PARITY_EN
  logic perr_set;

  assign frame_word = shreg;
  assign word_good  = complete && ((^shreg) == bit_in);
  assign perr_set   = complete && ((^shreg) != bit_in);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_set | (parity_err & ~clr_ovf);
    end
  end
`else
  assign frame_word = word_next;
  assign word_good  = complete;
  assign parity_err = 1'b0;
`endif

  // A pop on the same edge frees the slot, so a full FIFO still takes the word.
  assign push    = word_good && ((fill_count != CW'(DEPTH)) || pop);
  assign ovf_set = word_good && !push;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      bcnt       <= '0;
      shreg      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fill_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      bcnt       <= '0;
      shreg      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fill_count <= '0;
    end else begin
      if (bit_en) begin
        if (complete) begin
          bcnt  <= '0;
          shreg <= '0;
        end else begin
          bcnt  <= bcnt + BW'(1);
          shreg <= word_next;
        end
      end
      if (push) begin
        mem[wptr] <= frame_word;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fill_count <= fill_count + CW'(1);
        2'b01:   fill_count <= fill_count - CW'(1);
        default: fill_count <= fill_count;
      endcase
    end
  end

endmodule

// File: tb/tb_q_stream_rx.sv
// tb/tb_q_stream_rx.sv - scoreboard bench for q_stream_rx (WIDTH=8, DEPTH=4).
module tb_q_stream_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rest;
  logic             bit_in;
  logic             bit_en;
  logic             flush;
  logic             clr_ovf;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;
  logic [2:0]       fill_count;
  logic             overflow;
  logic             parity_err;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_perr = 1'b0;

  q_stream_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rest(rest), .bit_in(bit_in), .bit_en(bit_en), .flush(flush),
    .clr_ovf(clr_ovf), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .fill_count(fill_count), .overflow(overflow),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    repeat (gap) begin
      bit_in = 1'($urandom);
      tick();
    end
  endtask

  // Drives one frame; the model decides push/drop/parity result before the final edge.
  task automatic send_word(input logic [7:0] w, input int gap, input bit pop_last, input bit bad_par);
    logic [8:0] fr;
    int         nb;
    int         pre;
    bit         will_pop;
    bit         good;
    fr = {(^w) ^ bad_par, w};
`ifdef Q_STREAM_RX_PARITY_EN
    nb   = 9;
    good = !bad_par;
`else
    nb   = 8;
    good = 1'b1;
`endif
    for (int i = 0; i < nb - 1; i++) send_bit(fr[i], gap);
    check("pre_fill", fill_count, exp_q.size());
    pre      = exp_q.size();
    will_pop = pop_last && (pre > 0);
    if (will_pop) begin
      check("pop_head", word_data, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (good) begin
      if (pre < DEPTH || will_pop) exp_q.push_back(w);
      else exp_ovf = 1'b1;
    end else begin
      exp_perr = 1'b1;
    end
    word_ready = will_pop;
    bit_in     = fr[nb-1];
    bit_en     = 1'b1;
    tick();
    bit_en     = 1'b0;
    word_ready = 1'b0;
    check("fill", fill_count, exp_q.size());
    check("ovf", overflow, exp_ovf);
  endtask

  task automatic pop_one();
    check("pop_valid", word_valid, 1'b1);
    if (exp_q.size() > 0) check("pop_data", word_data, exp_q.pop_front());
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    check("drain_valid", word_valid, 1'b0);
    check("drain_fill", fill_count, 0);
  endtask

  task automatic clear_flags();
    clr_ovf = 1'b1;
    tick();
    clr_ovf  = 1'b0;
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    check("clr_perr", parity_err, 1'b0);
  endtask

  initial begin
    rest = 1'b0; bit_in = 1'b0; bit_en = 1'b0; flush = 1'b0;
    clr_ovf = 1'b0; word_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", word_valid, 1'b0);
    check("rst_fill", fill_count, 0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_data", word_data, 8'h00);
    rest = 1'b1;
    tick();

    send_word(8'hA5, 0, 1'b0, 1'b0);
    check("a5_valid", word_valid, 1'b1);
    check("a5_data", word_data, 8'hA5);
    drain();

    send_word(8'h3C, 1, 1'b0, 1'b0);
    drain();

    for (int i = 1; i <= 5; i++) send_word(8'(i), 0, 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    drain();
    clear_flags();

    for (int i = 1; i <= 4; i++) send_word(8'(8'h10 + i), 0, 1'b0, 1'b0);
    send_word(8'h15, 0, 1'b1, 1'b0);
    check("full_pop_ovf", overflow, 1'b0);
    drain();

    send_word(8'h77, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
    rest = 1'b0;
    #2;
    check("async_valid", word_valid, 1'b0);
    check("async_fill", fill_count, 0);
    tick();
    rest = 1'b1;
    exp_q.delete();
    send_word(8'hFF, 0, 1'b0, 1'b0);
    check("ff_data", word_data, 8'hFF);
    drain();

    for (int i = 1; i <= 5; i++) send_word(8'(8'h20 + i), 0, 1'b0, 1'b0);
    drain();
    send_word(8'h31, 0, 1'b0, 1'b0);
    send_word(8'h32, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_fill", fill_count, 0);
    check("flush_valid", word_valid, 1'b0);
    check("flush_keeps_ovf", overflow, 1'b1);
    send_word(8'h5A, 0, 1'b0, 1'b0);
    drain();
    clear_flags();

    word_ready = 1'b1;
    repeat (2) tick();
    word_ready = 1'b0;
    check("empty_ready_fill", fill_count, 0);

`ifdef Q_STREAM_RX_PARITY_EN
    send_word(8'h07, 0, 1'b0, 1'b0);
    check("par_ok_perr", parity_err, 1'b0);
    send_word(8'h07, 0, 1'b0, 1'b1);
    check("par_bad_perr", parity_err, 1'b1);
    drain();
    clear_flags();
`else
    send_word(8'h07, 0, 1'b0, 1'b0);
    check("noparity_perr", parity_err, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_stream_rx.md
# q_stream_rx

Serial receive end for the flip-flop data path: samples the 1-bit `q` stream leaving the `ff` stage and assembles it LSB-first into WIDTH-bit words. Completed words go into a small FIFO with a valid/ready output handshake. Lost words are reported through a sticky overflow flag. The block sits between the registered bit line and any word-level consumer, such as a checker or bus bridge.

## Interface
- `WIDTH`, 8: bits per word; ≥2.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

- `clk` in 1: single clock; all state updates on rising edge.
- `rest` in 1: asynchronous, active-low reset.
- `bit_in` in 1: serial data, connected to `ff.q`.
- `bit_en` in 1: `bit_in` is sampled on this edge when high.
- `flush` in 1: synchronous clear of the partial word and the FIFO.
- `clr_ovf` in 1: synchronous clear of `overflow` (and `parity_err` when enabled).
- `word_data` out WIDTH: head-of-FIFO word.
- `word_valid` out 1: FIFO non-empty.
- `word_ready` in 1: consumer accepts the head word.
- `fill_count` out $clog2(DEPTH+1): current number of FIFO entries.
- `overflow` out 1: sticky; a completed word was dropped because the FIFO was full.
- `parity_err` out 1: sticky; driven by the parity feature, tied 0 when the feature is compiled out.

## Operation
- Shift register plus bit counter `bcnt` (0..FRAME-1). FRAME = WIDTH, or WIDTH+1 with parity enabled.
- Each edge with `bit_en=1`: `bit_in` is placed at position `bcnt` (LSB first), then `bcnt` increments.
- When `bcnt` wraps FRAME-1→0, a word completes. The completed word includes the bit sampled on that same edge.
- On completion, the word is pushed to the FIFO if `fill_count<DEPTH`, or if a pop happens on the same edge. Otherwise the word is discarded and `overflow` is set to 1.
- Pop: `word_valid && word_ready` on an edge removes the head entry. With `word_valid=0`, `word_ready` has no effect.
- Simultaneous push and pop:
  - `fill_count` is unchanged.
  - When full, the push is accepted and `overflow` is not set.
- No bypass: a word pushed into an empty FIFO becomes valid on the next cycle.
- `flush=1`:
  - Sets `bcnt=0`, clears the partial word, and empties the FIFO.
  - Overrides push, pop and sampling on that edge.
  - Does not clear `overflow` or `parity_err`.
- `clr_ovf=1` clears the sticky flags.
  - A set event on the same edge wins, leaving the flag at 1.
- `word_data` is undefined-but-stable while `word_valid=0`. The bench must not check it then.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `fill_count`.

## Timing
- Reset (`rest=0`, asynchronous, any time):
  - Outputs: `word_valid=0`, `fill_count=0`, `overflow=0`, `parity_err=0`, `word_data=0`.
  - Internal state: `bcnt=0`, pointers 0.
- Reset in the middle of a frame discards the partial word. After `rest` returns high, the next sampled bit is bit 0.
- Latency: the last frame bit is sampled on edge N, and `word_valid`/`fill_count` reflect the new word after edge N.
- Throughput:
  - One word per FRAME enabled edges.
  - Pops are unconstrained, up to one per cycle.
- `fill_count` and `word_valid` are registered and change only on `clk` edges or at reset.

## Configuration
- `Q_STREAM_RX_PARITY_EN` defined:
  - FRAME=WIDTH+1. The extra bit, received after the MSB, is even parity over the data bits.
  - On mismatch, the word is not pushed and `parity_err` is set.
  - A parity-bad word never sets `overflow`.
- `Q_STREAM_RX_PARITY_EN` undefined:
  - FRAME=WIDTH.
  - `parity_err` is constant 0 and no parity logic is generated.

## Test plan
- Reset then stream: hold `rest=0` for 2 cycles, then stream 8'hA5 LSB-first (1,0,1,0,0,1,0,1) with `bit_en=1` and `word_ready=0` → after the 8th edge, `word_valid=1`, `word_data=8'hA5`, `fill_count=1`.
- Gapped enable: stream 8'h3C with `bit_en` toggling every other cycle → word completes only after the 8th enabled edge; disabled edges leave `bcnt` unchanged.
- Overflow: DEPTH=4 with `word_ready=0`, push 5 words 01,02,03,04,05 → `fill_count=4`, `overflow=1`, pops return 01..04. Then pulse `clr_ovf` → `overflow=0`.
- Full with simultaneous pop: FIFO full, 5th word completes on the same edge as a pop → `overflow` stays 0, `fill_count` stays 4, and 05 is last out.
- Reset and flush mid-frame:
  - Assert `rest` low after 3 bits, then send 8'hFF → word is 8'hFF, not corrupted by the partial word.
  - With 2 words queued, `flush=1` → `fill_count=0` and `word_valid=0` next cycle.
- Parity (with `Q_STREAM_RX_PARITY_EN`):
  - 8'h07 with parity bit 1 → accepted.
  - 8'h07 with parity bit 0 → `parity_err=1`, `fill_count` unchanged.
